// File: rtl/uart_hex_string_accumulator.sv
// Assembles toggle-handshake UART characters into a DIGITS-wide hex value, committed on CR/LF.
// Optional backspace editing (0x08/0x7F) is enabled by defining HEXACC_BACKSPACE_EN.
module uart_hex_string_accumulator #(
  parameter int DIGITS   = 4,
  parameter int OVF_MODE = 0,
  localparam int CW      = $clog2(DIGITS + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            ascii_data,
  input  logic                  received_toggle_signal,
  output logic [4*DIGITS-1:0]   hex_value,
  output logic                  commit_strobe,
  output logic [CW-1:0]         digit_count,
  output logic                  line_error
);

  localparam int VW = 4 * DIGITS;
  localparam logic [CW-1:0] FULL = CW'(DIGITS);

`ifdef HEXACC_BACKSPACE_EN
  localparam bit BS_EN = 1'b1;
`else
  localparam bit BS_EN = 1'b0;
`endif

  typedef enum logic [1:0] {S_EMPTY, S_ENTRY, S_ERROR} state_t;

  state_t          state, state_nxt;
  logic [VW-1:0]   shadow, shadow_nxt, hex_nxt;
  logic [CW-1:0]   count, count_nxt;
  logic            strobe_nxt, err_nxt;
  logic            prev_toggle;
  logic            evt;

  function automatic logic is_hex(input logic [7:0] c);
    return (c >= 8'h30 && c <= 8'h39) || (c >= 8'h41 && c <= 8'h46) ||
           (c >= 8'h61 && c <= 8'h66);
  endfunction

  function automatic logic is_term(input logic [7:0] c);
    return (c == 8'h0D) || (c == 8'h0A);
  endfunction

  function automatic logic is_bs(input logic [7:0] c);
    return BS_EN && ((c == 8'h08) || (c == 8'h7F));
  endfunction

  // Letters A-F/a-f share low nibbles 1..6, so adding 9 yields 10..15.
  function automatic logic [3:0] hex_nibble(input logic [7:0] c);
    return c[6] ? (c[3:0] + 4'd9) : c[3:0];
  endfunction

  function automatic logic [VW-1:0] shift_in(input logic [VW-1:0] s, input logic [3:0] n);
    logic [VW-1:0] r;
    r      = s << 4;
    r[3:0] = n;
    return r;
  endfunction

  assign evt         = (received_toggle_signal != prev_toggle);
  assign digit_count = count;

  always_comb begin
    state_nxt  = state;
    shadow_nxt = shadow;
    count_nxt  = count;
    hex_nxt    = hex_value;
    strobe_nxt = 1'b0;
    err_nxt    = line_error;
    if (evt && (ascii_data != 8'h20)) begin
      case (state)
        S_EMPTY: begin
          if (is_hex(ascii_data)) begin
            shadow_nxt = shift_in(shadow, hex_nibble(ascii_data));
            count_nxt  = CW'(1);
            state_nxt  = S_ENTRY;
          end else if (!is_term(ascii_data) && !is_bs(ascii_data)) begin
            state_nxt = S_ERROR;
            err_nxt   = 1'b1;
          end
        end
        S_ENTRY: begin
          if (is_hex(ascii_data)) begin
            if (count < FULL) begin
              shadow_nxt = shift_in(shadow, hex_nibble(ascii_data));
              count_nxt  = count + 1'b1;
            end else if (OVF_MODE == 0) begin
              shadow_nxt = shift_in(shadow, hex_nibble(ascii_data));
            end else begin
              state_nxt  = S_ERROR;
              err_nxt    = 1'b1;
              shadow_nxt = '0;
              count_nxt  = '0;
            end
          end else if (is_term(ascii_data)) begin
            hex_nxt    = shadow;
            strobe_nxt = 1'b1;
            err_nxt    = 1'b0;
            shadow_nxt = '0;
            count_nxt  = '0;
            state_nxt  = S_EMPTY;
          end else if (is_bs(ascii_data)) begin
            shadow_nxt = shadow >> 4;
            count_nxt  = count - 1'b1;
            if (count == CW'(1)) state_nxt = S_EMPTY;
          end else begin
            state_nxt  = S_ERROR;
            err_nxt    = 1'b1;
            shadow_nxt = '0;
            count_nxt  = '0;
          end
        end
        S_ERROR: begin
          if (is_term(ascii_data)) state_nxt = S_EMPTY;
        end
        default: state_nxt = S_EMPTY;
      endcase
    end
  end

  // Register stage: every consequence of a character lands on the same edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= S_EMPTY;
      shadow        <= '0;
      count         <= '0;
      hex_value     <= '0;
      commit_strobe <= 1'b0;
      line_error    <= 1'b0;
      prev_toggle   <= 1'b0;
    end else begin
      state         <= state_nxt;
      shadow        <= shadow_nxt;
      count         <= count_nxt;
      hex_value     <= hex_nxt;
      commit_strobe <= strobe_nxt;
      line_error    <= err_nxt;
      prev_toggle   <= received_toggle_signal;
    end
  end

endmodule

// File: tb/tb_uart_hex_string_accumulator.sv
// Directed bench for uart_hex_string_accumulator: one instance per overflow policy, shared stimulus.
module tb_uart_hex_string_accumulator;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  ascii_data = 8'h00;
  logic        tog = 1'b0;

  logic [15:0] hex_d, hex_r;
  logic        stb_d, stb_r;
  logic [2:0]  cnt_d, cnt_r;
  logic        err_d, err_r;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  uart_hex_string_accumulator #(.DIGITS(4), .OVF_MODE(0)) dut_drop (
    .clk(clk), .rst(rst), .ascii_data(ascii_data), .received_toggle_signal(tog),
    .hex_value(hex_d), .commit_strobe(stb_d), .digit_count(cnt_d), .line_error(err_d)
  );

  uart_hex_string_accumulator #(.DIGITS(4), .OVF_MODE(1)) dut_rej (
    .clk(clk), .rst(rst), .ascii_data(ascii_data), .received_toggle_signal(tog),
    .hex_value(hex_r), .commit_strobe(stb_r), .digit_count(cnt_r), .line_error(err_r)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] c);
    @(negedge clk);
    ascii_data = c;
    tog = ~tog;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_both(input string tag, input logic [15:0] hx, input logic stb,
                            input logic [2:0] cnt, input logic err);
    check({tag, " hex_d"}, {16'h0, hex_d}, {16'h0, hx});
    check({tag, " stb_d"}, {31'h0, stb_d}, {31'h0, stb});
    check({tag, " cnt_d"}, {29'h0, cnt_d}, {29'h0, cnt});
    check({tag, " err_d"}, {31'h0, err_d}, {31'h0, err});
    check({tag, " hex_r"}, {16'h0, hex_r}, {16'h0, hx});
    check({tag, " stb_r"}, {31'h0, stb_r}, {31'h0, stb});
    check({tag, " cnt_r"}, {29'h0, cnt_r}, {29'h0, cnt});
    check({tag, " err_r"}, {31'h0, err_r}, {31'h0, err});
  endtask

  logic [7:0] beef [5];

  initial begin
    beef = '{8'h62, 8'h65, 8'h65, 8'h66, 8'h0D};

    // Reset state
    idle(); idle();
    check_both("reset", 16'h0000, 1'b0, 3'd0, 1'b0);
    @(negedge clk); rst = 1'b1;
    idle();
    check_both("idle", 16'h0000, 1'b0, 3'd0, 1'b0);

    // "1aF3" CR
    send(8'h31); check_both("d1", 16'h0000, 1'b0, 3'd1, 1'b0);
    send(8'h61); check_both("d2", 16'h0000, 1'b0, 3'd2, 1'b0);
    send(8'h46); check_both("d3", 16'h0000, 1'b0, 3'd3, 1'b0);
    send(8'h33); check_both("d4", 16'h0000, 1'b0, 3'd4, 1'b0);
    send(8'h0D); check_both("cr1", 16'h1AF3, 1'b1, 3'd0, 1'b0);
    idle();      check_both("post1", 16'h1AF3, 1'b0, 3'd0, 1'b0);

    // "7" CR LF: single strobe
    send(8'h37);
    send(8'h0D); check_both("cr7", 16'h0007, 1'b1, 3'd0, 1'b0);
    send(8'h0A); check_both("lf7", 16'h0007, 1'b0, 3'd0, 1'b0);

    // "12345" CR: window shift vs reject
    send(8'h31); send(8'h32); send(8'h33); send(8'h34);
    send(8'h35);
    check("ovf cnt_d", {29'h0, cnt_d}, 32'd4);
    check("ovf err_d", {31'h0, err_d}, 32'd0);
    check("ovf cnt_r", {29'h0, cnt_r}, 32'd0);
    check("ovf err_r", {31'h0, err_r}, 32'd1);
    send(8'h0D);
    check("ovf hex_d", {16'h0, hex_d}, 32'h2345);
    check("ovf stb_d", {31'h0, stb_d}, 32'd1);
    check("ovf hex_r", {16'h0, hex_r}, 32'h0007);
    check("ovf stb_r", {31'h0, stb_r}, 32'd0);
    check("ovf err_r2", {31'h0, err_r}, 32'd1);
    send(8'h39);
    send(8'h0D); check_both("cr9", 16'h0009, 1'b1, 3'd0, 1'b0);

    // "4G5" CR: invalid character poisons the line
    send(8'h34);
    send(8'h47); check_both("badG", 16'h0009, 1'b0, 3'd0, 1'b1);
    send(8'h35); check_both("err5", 16'h0009, 1'b0, 3'd0, 1'b1);
    send(8'h0D); check_both("errcr", 16'h0009, 1'b0, 3'd0, 1'b1);

    // "AB", reset, "C" CR
    send(8'h41); send(8'h42);
    check_both("ab", 16'h0009, 1'b0, 3'd2, 1'b1);
    @(negedge clk); rst = 1'b0; tog = 1'b0;
    idle();
    check_both("midrst", 16'h0000, 1'b0, 3'd0, 1'b0);
    @(negedge clk); rst = 1'b1;
    send(8'h43);
    send(8'h0D); check_both("crC", 16'h000C, 1'b1, 3'd0, 1'b0);

    // "beef" CR with a toggle on every clock
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      ascii_data = beef[i];
      tog = ~tog;
    end
    idle();
    check_both("beef", 16'hBEEF, 1'b1, 3'd0, 1'b0);

    // Space is ignored mid-line
    send(8'h35);
    send(8'h20); check_both("space", 16'hBEEF, 1'b0, 3'd1, 1'b0);
    send(8'h36);
    send(8'h0D); check_both("cr56", 16'h0056, 1'b1, 3'd0, 1'b0);

    // "12" BS "3" CR
    send(8'h31); send(8'h32);
    send(8'h08);
`ifdef HEXACC_BACKSPACE_EN
    check_both("bs", 16'h0056, 1'b0, 3'd1, 1'b0);
    send(8'h33);
    send(8'h0D); check_both("crbs", 16'h0013, 1'b1, 3'd0, 1'b0);
`else
    check_both("bs", 16'h0056, 1'b0, 3'd0, 1'b1);
    send(8'h33);
    send(8'h0D); check_both("crbs", 16'h0056, 1'b0, 3'd0, 1'b1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
